fib_seq_engine: RTL and testbench

- Sequential, multi-cycle Fibonacci generator. Replaces the combinational Fibonacci module in the datapath wherever a registered, handshaked result is required.
- Accepts an index n over a valid/ready input channel and iterates the recurrence once per clock.
- Presents fib(n) plus status flags on a valid/ready output channel.
- Sits between the command source and any downstream consumer of Fibonacci results.

---
 rtl/fib_pkg.sv | 14 +
 rtl/fib_step.sv | 16 +
 rtl/fib_seq_engine.sv | 130 +++++++++++++
 tb/tb_fib_seq_engine.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the sequential Fibonacci engine: state encoding and
// default sizing used by the RTL and its bench.
package fib_pkg;

    typedef enum logic [1:0] {
        FIB_IDLE = 2'd0,
        FIB_CALC = 2'd1,
        FIB_DONE = 2'd2
    } fib_state_t;

    localparam int FIB_WIDTH = 32;
    localparam int FIB_MAX_N = 1000;

endpackage

// File: rtl/fib_step.sv
// One Fibonacci recurrence step: unsigned add of two terms with carry-out,
// kept separate so the overflow detection can be shared with other variants.
module fib_step
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fib_seq_engine.sv
// Multi-cycle Fibonacci generator with valid/ready request and result channels.
// One recurrence step per clock; all outputs are registered.
module fib_seq_engine
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH,
    parameter int MAX_N = FIB_MAX_N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] fib,
    output logic             overflow,
    output logic             err
);

    fib_state_t       state, state_nxt;
    logic [WIDTH-1:0] a, b, cnt;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf_a, ovf_b;
    logic             accept;
    logic             too_big;

    assign accept  = in_valid & in_ready;
    assign too_big = (n > WIDTH'(MAX_N));

    fib_step #(.WIDTH(WIDTH)) u_step (
        .a     (a),
        .b     (b),
        .sum   (sum),
        .carry (carry)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FIB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: out-of-range requests skip the iteration entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            FIB_IDLE: begin
                if (accept) begin
                    state_nxt = too_big ? FIB_DONE : FIB_CALC;
                end
            end
            FIB_CALC: begin
                if (cnt == '0) begin
                    state_nxt = FIB_DONE;
                end
            end
            FIB_DONE: begin
                if (out_valid && out_ready) begin
                    state_nxt = FIB_IDLE;
                end
            end
            default: state_nxt = FIB_IDLE;
        endcase
    end

    // Handshake flags registered from the next state so they track the state
    // register exactly, while in_ready stays low throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == FIB_IDLE);
            out_valid <= (state_nxt == FIB_DONE);
        end
    end

    // Recurrence and result registers; overflow follows the term held in a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a        <= '0;
            b        <= '0;
            cnt      <= '0;
            ovf_a    <= 1'b0;
            ovf_b    <= 1'b0;
            fib      <= '0;
            overflow <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                FIB_IDLE: begin
                    if (accept) begin
                        if (too_big) begin
                            fib      <= '0;
                            err      <= 1'b1;
                            overflow <= 1'b0;
                        end else begin
                            cnt   <= n;
                            a     <= '0;
                            b     <= WIDTH'(1);
                            ovf_a <= 1'b0;
                            ovf_b <= 1'b0;
                        end
                    end
                end
                FIB_CALC: begin
                    if (cnt != '0) begin
                        a     <= b;
                        b     <= sum;
                        ovf_a <= ovf_b;
                        ovf_b <= ovf_b | carry;
                        cnt   <= cnt - WIDTH'(1);
                    end else begin
                        fib      <= a;
                        overflow <= ovf_a;
                        err      <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_seq_engine.sv
// Bench for fib_seq_engine: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_fib_seq_engine;
    import fib_pkg::*;

    localparam int W = FIB_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] n = '0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] fib;
    logic         overflow;
    logic         err;

    int checks = 0;
    int errors = 0;

    bit rand_mode = 1'b0;
    bit dir_ready = 1'b1;

    fib_seq_engine #(.WIDTH(W), .MAX_N(FIB_MAX_N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n         (n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fib       (fib),
        .overflow  (overflow),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Consumer readiness, changed just after the falling edge.
    initial out_ready = 1'b1;
    always @(negedge clk) begin
        #1;
        out_ready = rand_mode ? 1'($urandom_range(0, 1)) : dir_ready;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: true Fibonacci tracked with saturation above 2^W for the
    // overflow flag, and a separate W-bit wrapping pair for the value.
    function automatic logic [W:0] fib_model(input int unsigned k);
        longint unsigned x = 0, y = 1, t;
        longint unsigned lim = 64'd1 << W;
        longint unsigned cap = 64'd1 << (W + 4);
        logic [W-1:0] mx = '0, my = W'(1), mt;
        for (int unsigned i = 0; i < k; i++) begin
            t  = x + y;
            x  = y;
            y  = (t > cap) ? cap : t;
            mt = mx + my;
            mx = my;
            my = mt;
        end
        return {(x >= lim), mx};
    endfunction

    // Transaction-level model: a request answers n+1 edges after acceptance
    // (immediately for out-of-range n); the engine is idle otherwise.
    logic         m_in_ready = 1'b0;
    logic         m_out_valid = 1'b0;
    logic [W-1:0] m_fib = '0;
    logic         m_ovf = 1'b0;
    logic         m_err = 1'b0;
    int unsigned  m_wait = 0;
    logic [W-1:0] p_fib = '0;
    logic         p_ovf = 1'b0;
    logic [W:0]   mr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in_ready  <= 1'b0;
            m_out_valid <= 1'b0;
            m_fib       <= '0;
            m_ovf       <= 1'b0;
            m_err       <= 1'b0;
            m_wait      <= 0;
        end else if (m_out_valid) begin
            if (out_ready) begin
                m_out_valid <= 1'b0;
                m_in_ready  <= 1'b1;
            end
        end else if (m_wait != 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_out_valid <= 1'b1;
                m_fib       <= p_fib;
                m_ovf       <= p_ovf;
                m_err       <= 1'b0;
            end
        end else if (m_in_ready && in_valid) begin
            m_in_ready <= 1'b0;
            if (n > W'(FIB_MAX_N)) begin
                m_out_valid <= 1'b1;
                m_fib       <= '0;
                m_ovf       <= 1'b0;
                m_err       <= 1'b1;
            end else begin
                mr = fib_model(int'(n));
                p_fib  <= mr[W-1:0];
                p_ovf  <= mr[W];
                m_wait <= int'(n) + 1;
            end
        end else begin
            m_in_ready <= 1'b1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("in_ready", in_ready, m_in_ready);
        check("out_valid", out_valid, m_out_valid);
        if (m_out_valid) begin
            check("fib", fib, m_fib);
            check("overflow", overflow, m_ovf);
            check("err", err, m_err);
        end
    end

    logic [W-1:0] got_fib;
    logic         got_ovf, got_err;

    // Present a request, wait for its result; checks the observed latency.
    task automatic issue(input logic [W-1:0] nv);
        int  idx;
        bit  acc;
        @(negedge clk);
        in_valid = 1'b1;
        n        = nv;
        acc      = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!acc) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n        = $urandom;
        idx      = 1;
        while (!out_valid && idx < 3000) begin
            @(negedge clk);
            idx++;
        end
        check("result_timeout", out_valid, 1);
        check("latency", idx, (nv > W'(FIB_MAX_N)) ? 1 : int'(nv) + 2);
        got_fib = fib;
        got_ovf = overflow;
        got_err = err;
    endtask

    // Wait for the output handshake; the engine must be ready right after.
    task automatic finish_req();
        int k = 0;
        while (out_valid && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("handshake_timeout", out_valid, 0);
        check("ready_after_hs", in_ready, 1);
    endtask

    task automatic run(input logic [W-1:0] nv, input logic [W-1:0] ef,
                       input logic eo, input logic ee, input string tag);
        issue(nv);
        check({tag, "_fib"}, got_fib, ef);
        check({tag, "_ovf"}, got_ovf, eo);
        check({tag, "_err"}, got_err, ee);
        finish_req();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W:0] pin;
        // Model pinned against known values.
        pin = fib_model(0);  check("model_f0", pin, {1'b0, W'(0)});
        pin = fib_model(20); check("model_f20", pin, {1'b0, W'(6765)});
        pin = fib_model(47); check("model_f47", pin, {1'b0, W'(32'd2971215073)});
        pin = fib_model(48); check("model_f48", pin, {1'b1, W'(32'd512559680)});

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_fib", fib, 0);
        check("rst_flags", {overflow, err}, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("first_ready", in_ready, 1);

        run(0, 0, 0, 0, "n0");
        run(1, 1, 0, 0, "n1");
        run(2, 1, 0, 0, "n2");
        run(10, 55, 0, 0, "n10");
        run(15, 610, 0, 0, "n15");
        run(20, 6765, 0, 0, "n20");
        run(47, 32'd2971215073, 0, 0, "n47");
        run(48, 32'd512559680, 1, 0, "n48");
        run(W'(FIB_MAX_N + 1), 0, 0, 1, "n1001");
        run(5, 5, 0, 0, "n5");
        run(W'(FIB_MAX_N), fib_model(FIB_MAX_N), fib_model(FIB_MAX_N) >> W, 0, "nmax");

        // Backpressure: result held, stray requests ignored.
        dir_ready = 1'b0;
        @(negedge clk);
        issue(10);
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            n        = 3;
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_fib", fib, 55);
            check("bp_ready", in_ready, 0);
            check("bp_flags", {overflow, err}, 0);
        end
        in_valid  = 1'b0;
        dir_ready = 1'b1;
        finish_req();

        // Asynchronous reset in the middle of an iteration.
        @(negedge clk);
        in_valid = 1'b1;
        n        = 20;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_ready", in_ready, 0);
        check("arst_fib", fib, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        run(20, 6765, 0, 0, "n20_after_rst");

        // Randomized traffic with a random consumer.
        rand_mode = 1'b1;
        for (int t = 0; t < 30; t++) begin
            logic [W-1:0] rn;
            rn = ($urandom_range(0, 7) == 0) ? W'($urandom_range(FIB_MAX_N + 1, 3000))
                                             : W'($urandom_range(0, 60));
            issue(rn);
            finish_req();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rand_mode = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
